// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer in front of an external combinational ALU.
// Holds a 4x4 register file and the architectural flag register.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_rs,
  input  logic [3:0] in_imm,
  output logic [3:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_o,
  input  logic [7:0] alu_flags,
  output logic [7:0] flags_q,
  output logic [3:0] wb_data,
  output logic       done,
  output logic       busy,
  input  logic [1:0] dbg_sel,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] regs [4];
  logic [1:0] rd_q;
  logic       accept;
  logic       uses_imm;
  logic       wr_reg;
  logic       wr_flags;

  assign accept   = in_valid && in_ready;
  assign uses_imm = (in_op == 4'b1001) || (in_op == 4'b1010);
  assign dbg_data = regs[dbg_sel];

  // Write enables are decoded from the latched opcode, so they stay stable in EXEC.
  assign wr_reg   = (alu_opcode >= 4'b0001) && (alu_opcode <= 4'b1010);
  assign wr_flags = ((alu_opcode >= 4'b0001) && (alu_opcode <= 4'b1000)) ||
                    (alu_opcode == 4'b1010) || (alu_opcode == 4'b1101);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // done is gated by rst so a reset landing in DONE suppresses the pulse.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = DONE;
      DONE: begin
        done       = !rst;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= 4'd0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      rd_q       <= 2'd0;
      flags_q    <= 8'd0;
      wb_data    <= 4'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else begin
      if (accept) begin
        alu_opcode <= in_op;
        alu_a      <= regs[in_rd];
        alu_b      <= uses_imm ? in_imm : regs[in_rs];
        rd_q       <= in_rd;
      end
      if (state == EXEC) begin
        wb_data <= alu_o;
        if (wr_reg)   regs[rd_q] <= alu_o;
        if (wr_flags) flags_q    <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs;
  logic [3:0] in_imm;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_o;
  logic [7:0] alu_flags;
  logic [7:0] flags_q;
  logic [3:0] wb_data;
  logic       done;
  logic       busy;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  typedef struct packed {
    logic [3:0]  wb;
    logic [7:0]  flags;
    logic [15:0] regs;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] m_regs [4];
  logic [7:0] m_flags;
  int         checks = 0;
  int         errors = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_flags(alu_flags), .flags_q(flags_q),
    .wb_data(wb_data), .done(done), .busy(busy),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; undefined opcodes return all-ones flags so a stray flag write shows up.
  function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] o;
    logic       c, v, defined;
    o = 4'hF; c = 1'b0; v = 1'b0; defined = 1'b1; s = 5'd0;
    case (op)
      4'd1, 4'd10: begin
        s = {1'b0, a} + {1'b0, b};
        o = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (o[3] != a[3]);
      end
      4'd2, 4'd13: begin
        o = a - b; c = (a >= b); v = (a[3] != b[3]) && (o[3] != a[3]);
      end
      4'd3: o = a & b;
      4'd4: o = a | b;
      4'd5: o = a ^ b;
      4'd6: o = ~a;
      4'd7: begin o = {a[2:0], 1'b0}; c = a[3]; end
      4'd8: begin o = {1'b0, a[3:1]}; c = a[0]; end
      4'd9: o = b;
      4'd15: begin o = 4'd0; defined = 1'b0; end
      default: defined = 1'b0;
    endcase
    if (!defined) return {8'hFF, o};
    return {(a < b), (a > b), (a != b), (a == b), v, o[3], c, (o == 4'd0), o};
  endfunction

  always_comb {alu_flags, alu_o} = alu_ref(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_flags = 8'd0;
    sb.delete();
  endtask

  // Reference sequencer step taken at the accept edge; pushes the expected completion.
  task automatic model_accept(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] imm);
    logic [3:0]  a, b;
    logic [11:0] r;
    exp_t        e;
    a = m_regs[rd];
    b = (op == 4'd9 || op == 4'd10) ? imm : m_regs[rs];
    r = alu_ref(op, a, b);
    if (op >= 4'd1 && op <= 4'd10) m_regs[rd] = r[3:0];
    if ((op >= 4'd1 && op <= 4'd8) || op == 4'd10 || op == 4'd13) m_flags = r[11:4];
    e.wb    = r[3:0];
    e.flags = m_flags;
    e.regs  = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_imm = imm;
  endtask

  task automatic check_regs(input string tag, input logic [15:0] regs);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check(tag, 32'(dbg_data), 32'(regs[4*i +: 4]));
    end
  endtask

  task automatic check_done();
    exp_t e;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("wb_data", 32'(wb_data), 32'(e.wb));
      check("flags_q", 32'(flags_q), 32'(e.flags));
      check_regs("dbg_reg", e.regs);
    end
  endtask

  // Issue one instruction, scramble the inputs after accept, then await completion.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] imm);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_wait", 32'(in_ready), 32'd1);
    drive(op, rd, rs, imm);
    model_accept(op, rd, rs, imm);
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 4'($urandom); in_rd = 2'($urandom); in_rs = 2'($urandom); in_imm = 4'($urandom);
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    check("done_latency", 32'(n), 32'd1);
    if (done) check_done();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_again", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         acc_cyc [$];
    int         cyc, idx, since, dones;
    logic [3:0] p_op  [3];
    logic [1:0] p_rd  [3];
    logic [1:0] p_rs  [3];
    logic [3:0] p_imm [3];

    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_rd = 2'd0; in_rs = 2'd0; in_imm = 4'd0; dbg_sel = 2'd0;
    model_reset();

    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_a", 32'(alu_a), 32'd0);
    check("rst_b", 32'(alu_b), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_wb", 32'(wb_data), 32'd0);
    @(negedge clk);
    check("rst_ready2", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check_regs("post_rst_reg", 16'd0);
    @(negedge clk);

    issue(4'd9, 2'd1, 2'd0, 4'd7);
    check("ldi_flags_const", 32'(flags_q), 32'h00);
    issue(4'd9, 2'd2, 2'd0, 4'd9);
    issue(4'd1, 2'd1, 2'd2, 4'd0);
    check("add_flags_const", 32'(flags_q), 32'hA3);
    check("add_wb_const", 32'(wb_data), 32'h0);

    issue(4'd9, 2'd1, 2'd0, 4'd5);
    issue(4'd9, 2'd2, 2'd0, 4'd5);
    issue(4'd13, 2'd1, 2'd2, 4'd0);
    check("cmp_flags_const", 32'(flags_q), 32'h13);
    dbg_sel = 2'd1; #1;
    check("cmp_r1_const", 32'(dbg_data), 32'd5);

    issue(4'd15, 2'd1, 2'd2, 4'd0);
    check("undef_wb_const", 32'(wb_data), 32'd0);
    issue(4'd0, 2'd2, 2'd1, 4'd0);
    issue(4'd12, 2'd1, 2'd1, 4'd0);
    issue(4'd1, 2'd2, 2'd2, 4'd0);
    issue(4'd3, 2'd2, 2'd1, 4'd0);
    issue(4'd10, 2'd3, 2'd0, 4'd14);
    issue(4'd7, 2'd3, 2'd0, 4'd0);
    issue(4'd8, 2'd1, 2'd0, 4'd0);
    issue(4'd6, 2'd0, 2'd0, 4'd0);

    // Back-to-back: in_valid held high with the next instruction presented while busy.
    p_op[0] = 4'd10; p_rd[0] = 2'd3; p_rs[0] = 2'd0; p_imm[0] = 4'd4;
    p_op[1] = 4'd2;  p_rd[1] = 2'd3; p_rs[1] = 2'd1; p_imm[1] = 4'd0;
    p_op[2] = 4'd5;  p_rd[2] = 2'd0; p_rs[2] = 2'd3; p_imm[2] = 4'd0;
    cyc = 0; idx = 0; since = -10; dones = 0;
    while ((idx < 3 || dones < 3) && cyc < 40) begin
      since++;
      if (done) begin dones++; check_done(); end
      if (since == 1 || since == 2) check("bb_ready_low", 32'(in_ready), 32'd0);
      if (idx < 3) begin
        drive(p_op[idx], p_rd[idx], p_rs[idx], p_imm[idx]);
        if (in_ready) begin
          model_accept(p_op[idx], p_rd[idx], p_rs[idx], p_imm[idx]);
          acc_cyc.push_back(cyc);
          idx++;
          since = 0;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("bb_dones", 32'(dones), 32'd3);
    check("bb_accepts", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("bb_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("bb_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    repeat (2) @(negedge clk);

    // Reset during EXEC of ADI R0,+3 must discard the instruction.
    issue(4'd9, 2'd0, 2'd0, 4'd6);
    drive(4'd10, 2'd0, 2'd0, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_ready_rel", 32'(in_ready), 32'd1);
    check("abort_flags", 32'(flags_q), 32'd0);
    dbg_sel = 2'd0; #1;
    check("abort_r0", 32'(dbg_data), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    issue(4'd10, 2'd0, 2'd0, 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
